// File: rtl/sw_debounce_pkg.sv
// Shared types and helpers for the switch/button debouncer.
// Holds the per-bit FSM state encoding and the hold-counter width rule.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW,
    ST_WAIT_HIGH,
    ST_HIGH,
    ST_WAIT_LOW
  } db_state_t;

  // Counter must be able to hold values up to n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser chain, debounce FSM with hold counter,
// and registered stable level plus one-cycle rise/fall strobes.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_pin,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic commit
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit IMMEDIATE = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sw_pin};
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;

    unique case (state_q)
      ST_LOW: begin
        if (s) begin
          if (IMMEDIATE) begin
            state_d  = ST_HIGH;
            stable_d = 1'b1;
            rise_d   = 1'b1;
            cnt_d    = '0;
          end else begin
            state_d = ST_WAIT_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_HIGH;
          stable_d = 1'b1;
          rise_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          if (IMMEDIATE) begin
            state_d  = ST_LOW;
            stable_d = 1'b0;
            fall_d   = 1'b1;
            cnt_d    = '0;
          end else begin
            state_d = ST_WAIT_LOW;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_WAIT_LOW: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_LOW;
          stable_d = 1'b0;
          fall_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // Unregistered commit lets the top register `changed` on the same edge as the strobes.
  assign commit = rise_d | fall_d;
  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounced switch/button input conditioner: WIDTH independent bit
// debouncers plus a shared one-cycle `changed` strobe.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  logic [WIDTH-1:0] commit;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .sw_pin(sw[i]),
      .stable(sw_stable[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i]),
      .commit(commit[i])
    );
  end

  always_comb begin
    changed_d = |commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Expected {stable,rise,fall,changed} vectors are queued per driven cycle and popped after each edge.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [3:0] sw_stable, sw_rise, sw_fall;
  logic       changed;

  logic [12:0] exp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH          (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .sw_stable(sw_stable),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .changed  (changed)
  );

  task automatic push_exp(input logic [3:0] st, input logic [3:0] ri,
                          input logic [3:0] fa, input logic ch);
    exp_q.push_back({st, ri, fa, ch});
  endtask

  task automatic do_reset(input logic [3:0] pin);
    rst_n = 1'b0;
    sw    = pin;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    rst_n = 1'b0;
    sw    = 4'hF;
    for (int it = 1; it <= 3; it++) begin
      push_exp(4'h0, 4'h0, 4'h0, 1'b0);
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      n_compared++;
      if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL reset_hold it=%0d got=%h exp=%h", it, {sw_stable, sw_rise, sw_fall, changed}, e);
      end
    end
    rst_n = 1'b1;
    for (int it = 1; it <= 8; it++) begin
      push_exp((it >= 6) ? 4'hF : 4'h0, (it == 6) ? 4'hF : 4'h0, 4'h0, it == 6);
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      n_compared++;
      if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL reset_high_rise it=%0d got=%h exp=%h", it, {sw_stable, sw_rise, sw_fall, changed}, e);
      end
    end
    // Mid-cycle reset must clear a nonzero sw_stable without a clock edge.
    #2 rst_n = 1'b0;
    push_exp(4'h0, 4'h0, 4'h0, 1'b0);
    #1;
    e = exp_q.pop_front();
    n_compared++;
    if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
      n_mismatched++;
      $display("[TB] FAIL reset_async got=%h exp=%h", {sw_stable, sw_rise, sw_fall, changed}, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bounce();
    logic [12:0] e;
    logic [3:0]  pat [5] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1};
    do_reset(4'h0);
    for (int it = 1; it <= 14; it++) begin
      sw = (it <= 5) ? pat[it-1] : 4'h1;
      push_exp((it >= 10) ? 4'h1 : 4'h0, (it == 10) ? 4'h1 : 4'h0, 4'h0, it == 10);
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      n_compared++;
      if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL bounce it=%0d got=%h exp=%h", it, {sw_stable, sw_rise, sw_fall, changed}, e);
      end
    end
  endtask

  task automatic test_glitch();
    logic [12:0] e;
    do_reset(4'h0);
    for (int it = 1; it <= 12; it++) begin
      sw = (it <= 3) ? 4'h4 : 4'h0;
      push_exp(4'h0, 4'h0, 4'h0, 1'b0);
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      n_compared++;
      if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL glitch it=%0d got=%h exp=%h", it, {sw_stable, sw_rise, sw_fall, changed}, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [12:0] e;
    do_reset(4'h0);
    sw = 4'h8;
    for (int it = 1; it <= 8; it++) begin
      push_exp((it >= 6) ? 4'h8 : 4'h0, (it == 6) ? 4'h8 : 4'h0, 4'h0, it == 6);
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      n_compared++;
      if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL simul_setup it=%0d got=%h exp=%h", it, {sw_stable, sw_rise, sw_fall, changed}, e);
      end
    end
    sw = 4'h2;
    for (int it = 1; it <= 10; it++) begin
      push_exp((it >= 6) ? 4'h2 : 4'h8, (it == 6) ? 4'h2 : 4'h0,
               (it == 6) ? 4'h8 : 4'h0, it == 6);
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      n_compared++;
      if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL simul_swap it=%0d got=%h exp=%h", it, {sw_stable, sw_rise, sw_fall, changed}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    do_reset(4'h0);
    sw = 4'h1;
    for (int it = 1; it <= 3; it++) begin
      push_exp(4'h0, 4'h0, 4'h0, 1'b0);
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      n_compared++;
      if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL midrst_pre it=%0d got=%h exp=%h", it, {sw_stable, sw_rise, sw_fall, changed}, e);
      end
    end
    #2 rst_n = 1'b0;
    push_exp(4'h0, 4'h0, 4'h0, 1'b0);
    #1;
    e = exp_q.pop_front();
    n_compared++;
    if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_assert got=%h exp=%h", {sw_stable, sw_rise, sw_fall, changed}, e);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int it = 1; it <= 8; it++) begin
      push_exp((it >= 6) ? 4'h1 : 4'h0, (it == 6) ? 4'h1 : 4'h0, 4'h0, it == 6);
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      n_compared++;
      if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL midrst_post it=%0d got=%h exp=%h", it, {sw_stable, sw_rise, sw_fall, changed}, e);
      end
    end
  endtask

  task automatic test_long_hold();
    logic [12:0] e;
    do_reset(4'h0);
    for (int it = 1; it <= 115; it++) begin
      sw = (it <= 100) ? 4'h2 : 4'h0;
      push_exp((it >= 6 && it <= 105) ? 4'h2 : 4'h0, (it == 6) ? 4'h2 : 4'h0,
               (it == 106) ? 4'h2 : 4'h0, (it == 6) || (it == 106));
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      n_compared++;
      if ({sw_stable, sw_rise, sw_fall, changed} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL long_hold it=%0d got=%h exp=%h", it, {sw_stable, sw_rise, sw_fall, changed}, e);
      end
    end
  endtask

  initial begin
    $display("[TB] sw_debounce bench start");
    test_reset();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_long_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
